// File: rtl/amp_pwr_seq_if.sv
// Amplifier power-sequencer signal bundle: fault inputs, lockout clear and
// the registered control/status outputs. The sequencer sits on the slave side.
interface amp_pwr_seq_if #(
  parameter int unsigned NUM_AMP = 2,
  parameter int unsigned RW      = 2
);
  logic [NUM_AMP-1:0] Flt_n;
  logic               clr_lockout;
  logic               sht_dwn;
  logic               mute;
  logic               lockout;
  logic [NUM_AMP-1:0] fault_src;
  logic [RW-1:0]      retry_cnt;

  modport master (
    output Flt_n, clr_lockout,
    input  sht_dwn, mute, lockout, fault_src, retry_cnt
  );

  modport slave (
    input  Flt_n, clr_lockout,
    output sht_dwn, mute, lockout, fault_src, retry_cnt
  );
endinterface

// File: rtl/amp_pwr_seq.sv
// Amplifier power/fault sequencer: synchronises and debounces per-amp fault
// lines, sequences power-up -> muted settle -> run, and on a fault shuts the
// amps down, cools down and retries a bounded number of times before lockout.
module amp_pwr_seq #(
  parameter int unsigned NUM_AMP    = 2,
  parameter int unsigned PWRUP_CYC  = 250000,
  parameter int unsigned UNMUTE_CYC = 1024,
  parameter int unsigned DBNC_CYC   = 4,
  parameter int unsigned COOL_CYC   = 2500000,
  parameter int unsigned MAX_RETRY  = 3,
  parameter int unsigned RW         = $clog2(MAX_RETRY + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  amp_pwr_seq_if.slave       bus
);

  localparam int unsigned MaxPu  = (PWRUP_CYC > UNMUTE_CYC) ? PWRUP_CYC : UNMUTE_CYC;
  localparam int unsigned MaxCyc = (MaxPu > COOL_CYC) ? MaxPu : COOL_CYC;
  localparam int unsigned CW     = $clog2(MaxCyc + 1);
  localparam int unsigned DW     = $clog2(DBNC_CYC + 1);

  localparam logic [CW-1:0] PwrupLast  = CW'(PWRUP_CYC - 1);
  localparam logic [CW-1:0] SettleLast = CW'(UNMUTE_CYC - 1);
  localparam logic [CW-1:0] CoolLast   = CW'(COOL_CYC - 1);
  // Run counter parks here once the healthy-run credit has been given.
  localparam logic [CW-1:0] RunDone    = CW'(PWRUP_CYC);
  localparam logic [DW-1:0] DbncMax    = DW'(DBNC_CYC);
  localparam logic [RW-1:0] RetryMax   = RW'(MAX_RETRY);

  typedef enum logic [2:0] {StPwrup, StSettle, StRun, StCool, StLockout} state_e;

  logic [NUM_AMP-1:0] sync1_q, sync2_q;
  logic [DW-1:0]      dcnt_q [NUM_AMP];
  logic [DW-1:0]      dcnt_d [NUM_AMP];
  logic [NUM_AMP-1:0] flt_q, flt_d;
  logic               fault_any;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [RW-1:0]      retry_q, retry_d;
  logic [NUM_AMP-1:0] fsrc_q, fsrc_d;
  logic               sht_dwn_q, sht_dwn_d;
  logic               mute_q, mute_d;
  logic               lockout_q, lockout_d;

  // Two-flop synchroniser; idles high so reset never looks like a fault.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= bus.Flt_n;
      sync2_q <= sync1_q;
    end
  end

  // Per-channel debounce: count consecutive low cycles, saturating at DBNC_CYC.
  always_comb begin
    for (int i = 0; i < NUM_AMP; i++) begin
      dcnt_d[i] = dcnt_q[i];
      if (sync2_q[i]) begin
        dcnt_d[i] = '0;
      end else if (dcnt_q[i] < DbncMax) begin
        dcnt_d[i] = dcnt_q[i] + DW'(1);
      end
      flt_d[i] = (dcnt_d[i] == DbncMax);
    end
  end

  // Debounce counters and qualified-fault flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_AMP; i++) dcnt_q[i] <= '0;
      flt_q <= '0;
    end else begin
      for (int i = 0; i < NUM_AMP; i++) dcnt_q[i] <= dcnt_d[i];
      flt_q <= flt_d;
    end
  end

  assign fault_any = |flt_q;

  // Sequencer next state, shared counter, retry/fault bookkeeping and outputs.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    fsrc_d  = fsrc_q;
    unique case (state_q)
      StPwrup: begin
        if (cnt_q == PwrupLast) state_d = StSettle;
        else                    cnt_d   = cnt_q + CW'(1);
      end
      StSettle, StRun: begin
        fsrc_d = fsrc_q | flt_q;
        // A fault pre-empts both the unmute and the healthy-run credit.
        if (fault_any) begin
          if (retry_q < RetryMax) begin
            retry_d = retry_q + RW'(1);
            state_d = StCool;
          end else begin
            state_d = StLockout;
          end
        end else if (state_q == StSettle) begin
          if (cnt_q == SettleLast) state_d = StRun;
          else                     cnt_d   = cnt_q + CW'(1);
        end else if (cnt_q == PwrupLast) begin
          retry_d = '0;
          cnt_d   = RunDone;
        end else if (cnt_q < PwrupLast) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      StCool: begin
        if (cnt_q == CoolLast) state_d = StPwrup;
        else                   cnt_d   = cnt_q + CW'(1);
      end
      StLockout: begin
        if (bus.clr_lockout) begin
          state_d = StPwrup;
          retry_d = '0;
          fsrc_d  = '0;
        end
      end
      default: state_d = StPwrup;
    endcase
    if (state_d != state_q) cnt_d = '0;

    sht_dwn_d = !((state_d == StSettle) || (state_d == StRun));
    mute_d    = (state_d != StRun);
    lockout_d = (state_d == StLockout);
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StPwrup;
      cnt_q     <= '0;
      retry_q   <= '0;
      fsrc_q    <= '0;
      sht_dwn_q <= 1'b1;
      mute_q    <= 1'b1;
      lockout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retry_q   <= retry_d;
      fsrc_q    <= fsrc_d;
      sht_dwn_q <= sht_dwn_d;
      mute_q    <= mute_d;
      lockout_q <= lockout_d;
    end
  end

  assign bus.sht_dwn   = sht_dwn_q;
  assign bus.mute      = mute_q;
  assign bus.lockout   = lockout_q;
  assign bus.fault_src = fsrc_q;
  assign bus.retry_cnt = retry_q;

endmodule
